// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared codes, limits, FSM states and pattern map for the gesture encoder
package gesture_pkg;

    localparam logic [7:0] GEST_UNKNOWN = 8'h00;
    localparam logic [7:0] GEST_OPEN    = 8'h01;
    localparam logic [7:0] GEST_CLOSED  = 8'h02;

    localparam int MIN_US  = 500;
    localparam int MAX_US  = 2500;
    localparam int WIDTH_W = 12;

    localparam int FINGER_THUMB  = 0;
    localparam int FINGER_INDEX  = 1;
    localparam int FINGER_MIDDLE = 2;
    localparam int FINGER_RING   = 3;
    localparam int FINGER_PINKY  = 4;
    localparam int NUM_FINGERS   = FINGER_PINKY + 1;

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        EVALUATE = 2'd1,
        FAULT    = 2'd2
    } state_t;

    // Finger pattern (1 = closed) to gesture code.
    function automatic logic [7:0] map_pattern(input logic [NUM_FINGERS-1:0] p);
        if (p == '0)
            return GEST_OPEN;
        else if (p == '1)
            return GEST_CLOSED;
        else
            return GEST_UNKNOWN;
    endfunction

endpackage

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - one servo-PWM channel: synchronizer, 1 us prescaler, width capture, gap timeout
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   pwm           raw PWM pin, asynchronous to clk
//   width_valid   one-cycle pulse when an in-range width is latched
//   width         last accepted pulse width in us
//   timeout       high from a rising-edge gap of TIMEOUT_US until the next accepted width
module pwm_capture
    import gesture_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 25000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm,
    output logic               width_valid,
    output logic [WIDTH_W-1:0] width,
    output logic               timeout
);

    localparam int PRESC = CLK_HZ / 1_000_000;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int GW    = $clog2(TIMEOUT_US + 1);

    // sync[1:0] is the 2-FF synchronizer, sync[2] the previous synchronized level.
    logic [2:0]         sync;
    // Edges are only trusted once all three stages hold real pin samples, so a
    // pulse already high when reset releases is not mistaken for a rising edge.
    logic [1:0]         fill;
    logic               armed;
    logic [PW-1:0]      presc;
    logic [WIDTH_W-1:0] cnt;
    logic [GW-1:0]      gap;

    logic               rise;
    logic               fall;
    logic               tick;
    logic [WIDTH_W-1:0] cnt_now;
    logic               accept;

    assign rise    = (fill == 2'd3) && sync[1] && !sync[2];
    assign fall    = (fill == 2'd3) && !sync[1] && sync[2];
    assign tick    = (presc == PW'(PRESC - 1));
    // Include the tick landing on the falling-edge cycle so an N us pulse reads N.
    assign cnt_now = (tick && cnt != '1) ? cnt + 1'b1 : cnt;
    assign accept  = fall && armed &&
                     (cnt_now >= WIDTH_W'(MIN_US)) && (cnt_now <= WIDTH_W'(MAX_US));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '0;
            fill        <= '0;
            armed       <= 1'b0;
            presc       <= '0;
            cnt         <= '0;
            gap         <= '0;
            width       <= '0;
            width_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            sync        <= {sync[1:0], pwm};
            width_valid <= 1'b0;
            if (fill != 2'd3)
                fill <= fill + 1'b1;

            if (rise || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            if (rise) begin
                cnt   <= '0;
                gap   <= '0;
                armed <= 1'b1;
            end else begin
                if (tick && cnt != '1)
                    cnt <= cnt + 1'b1;
                if (tick && gap != GW'(TIMEOUT_US))
                    gap <= gap + 1'b1;
                if (fall)
                    armed <= 1'b0;
                if (accept) begin
                    width       <= cnt_now;
                    width_valid <= 1'b1;
                end
            end

            if (accept)
                timeout <= 1'b0;
            else if (tick && gap == GW'(TIMEOUT_US - 1))
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/gesture_encoder.sv
// rtl/gesture_encoder.sv - five-finger PWM capture to debounced gesture code with channel fault
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   pwm_in[4:0]     per-finger servo PWM (thumb, index, middle, ring, pinky)
//   gesture[7:0]    current gesture code
//   gesture_valid   one-cycle pulse whenever gesture changes
//   fault           high while in the FAULT state
// Build option: define GESTURE_DEBOUNCE_EN to require STABLE_FRAMES matching
// frames before the gesture changes; otherwise every differing frame updates it.
module gesture_encoder
    import gesture_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int CLOSE_US      = 1450,
    parameter int TIMEOUT_US    = 25000,
    parameter int STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] pwm_in,
    output logic [7:0] gesture,
    output logic       gesture_valid,
    output logic       fault
);

    logic [NUM_FINGERS-1:0] width_valid;
    logic [NUM_FINGERS-1:0] timeout;
    logic [NUM_FINGERS-1:0] pattern;
    logic [NUM_FINGERS-1:0] mask;
    logic [WIDTH_W-1:0]     width [NUM_FINGERS];

    for (genvar i = 0; i < NUM_FINGERS; i++) begin : g_ch
        pwm_capture #(
            .CLK_HZ     (CLK_HZ),
            .TIMEOUT_US (TIMEOUT_US)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .pwm         (pwm_in[i]),
            .width_valid (width_valid[i]),
            .width       (width[i]),
            .timeout     (timeout[i])
        );
        assign pattern[i] = (width[i] < WIDTH_W'(CLOSE_US));
    end

    state_t     state;
    logic       any_to;
    logic       mask_full;
    logic [7:0] cand;
    logic [7:0] cand_q;
    logic       upd_pend;
    logic       do_update;

    assign any_to    = |timeout;
    assign mask_full = &mask;
    assign cand      = map_pattern(pattern);

`ifdef GESTURE_DEBOUNCE_EN
    localparam int MW = $clog2(STABLE_FRAMES + 1);

    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_next;
    logic [7:0]    prev_cand;

    always_comb begin
        match_next = MW'(1);
        if (cand == prev_cand)
            match_next = (match_cnt == MW'(STABLE_FRAMES)) ? match_cnt : match_cnt + 1'b1;
    end

    assign do_update = (match_next == MW'(STABLE_FRAMES)) && (cand != gesture);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            prev_cand <= GEST_UNKNOWN;
        end else if (any_to) begin
            match_cnt <= '0;
        end else if (state == EVALUATE) begin
            match_cnt <= match_next;
            prev_cand <= cand;
        end
    end
`else
    assign do_update = (cand != gesture);
`endif

    // Clearing the mask always reloads it with this cycle's width_valid bits so
    // a width arriving in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACQUIRE;
            mask          <= '0;
            gesture       <= GEST_UNKNOWN;
            gesture_valid <= 1'b0;
            fault         <= 1'b0;
            cand_q        <= GEST_UNKNOWN;
            upd_pend      <= 1'b0;
        end else begin
            gesture_valid <= 1'b0;
            if (any_to) begin
                state    <= FAULT;
                fault    <= 1'b1;
                mask     <= width_valid;
                upd_pend <= 1'b0;
                if (gesture != GEST_UNKNOWN) begin
                    gesture       <= GEST_UNKNOWN;
                    gesture_valid <= 1'b1;
                end
            end else begin
                case (state)
                    ACQUIRE: begin
                        mask <= mask | width_valid;
                        if (upd_pend) begin
                            gesture       <= cand_q;
                            gesture_valid <= 1'b1;
                            upd_pend      <= 1'b0;
                        end
                        if (mask_full)
                            state <= EVALUATE;
                    end
                    EVALUATE: begin
                        mask     <= width_valid;
                        cand_q   <= cand;
                        upd_pend <= do_update;
                        state    <= ACQUIRE;
                    end
                    FAULT: begin
                        if (mask_full) begin
                            state <= ACQUIRE;
                            fault <= 1'b0;
                            mask  <= width_valid;
                        end else begin
                            mask <= mask | width_valid;
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gesture_encoder.sv
// tb/tb_gesture_encoder.sv - scoreboard bench for gesture_encoder
`timescale 1ns/1ps
module tb_gesture_encoder;

    localparam int CLK_HZ     = 2_000_000;
    localparam int TIMEOUT_US = 4000;
    localparam int US         = 1000;
`ifdef GESTURE_DEBOUNCE_EN
    localparam int NF = 3;
`else
    localparam int NF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] pwm_in = 5'b0;
    logic [7:0] gesture;
    logic       gesture_valid;
    logic       fault;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int  wv_seen = 0;
    time t_fault = 0;
    time t_last  = 0;

    gesture_encoder #(
        .CLK_HZ        (CLK_HZ),
        .CLOSE_US      (1450),
        .TIMEOUT_US    (TIMEOUT_US),
        .STABLE_FRAMES (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pwm_in        (pwm_in),
        .gesture       (gesture),
        .gesture_valid (gesture_valid),
        .fault         (fault)
    );

    always #250 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every gesture_valid pulse must match the next expected code.
    always @(negedge clk) begin
        if (rst_n && gesture_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got gesture %02h expected no pulse", gesture);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (gesture != e) begin
                    errors++;
                    $display("FAIL pulse_value: got %02h expected %02h", gesture, e);
                end
            end
        end
        if (rst_n && |dut.width_valid)
            wv_seen++;
    end

    always @(posedge fault) t_fault = $time;

    // One frame: enabled channels rise together, each falls after its width.
    task automatic frame(input int w[5], input logic [4:0] en, input int period);
        for (int t = 0; t < period; t++) begin
            for (int c = 0; c < 5; c++)
                pwm_in[c] = en[c] && (t < w[c]);
            #(US);
        end
    endtask

    task automatic frames(input int n, input int w[5], input int period, input int push_at,
                          input logic [7:0] code);
        for (int f = 1; f <= n; f++) begin
            if (f == push_at)
                exp_q.push_back(code);
            frame(w, 5'h1F, period);
        end
    endtask

    initial begin
        #(60_000 * US);
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        #(1 * US + 100);
        check("reset_gesture", gesture, 0);
        check("reset_valid", gesture_valid, 0);
        check("reset_fault", fault, 0);
        rst_n = 1'b1;
        #(2 * US);

        // All open: 1500 us.
        frames(3, '{1500, 1500, 1500, 1500, 1500}, 1600, NF, 8'h01);
        check("open_pending", exp_q.size(), 0);
        check("open_gesture", gesture, 8'h01);

        // All closed: 1400 us.
        frames(3, '{1400, 1400, 1400, 1400, 1400}, 1500, NF, 8'h02);
        check("closed_pending", exp_q.size(), 0);
        check("closed_gesture", gesture, 8'h02);

        // Out-of-range widths on the thumb are discarded.
        frame('{3000, 1400, 1400, 1400, 1400}, 5'h1F, 3100);
        check("long_mask_bit", dut.mask[0], 0);
        t_last = $time;
        frame('{300, 1400, 1400, 1400, 1400}, 5'h1F, 1500);
        check("short_mask_bit", dut.mask[0], 0);
        check("discard_gesture", gesture, 8'h02);

        // Ring channel stops; the first of these frames completes the mask with
        // an all-closed pattern, then the timeout forces gesture to 00.
        exp_q.push_back(8'h00);
        for (int f = 0; f < 3; f++)
            frame('{1400, 1400, 1400, 1400, 1400}, 5'b10111, 1500);
        check("fault_high", fault, 1);
        check("fault_gesture", gesture, 0);
        check("fault_pending", exp_q.size(), 0);
        // Two synchronizer stages plus two register stages at the 0.5 us bench clock.
        check("fault_time_lo", int'((t_fault - t_last) / US) >= TIMEOUT_US, 1);
        check("fault_time_hi", int'((t_fault - t_last) / US) <= TIMEOUT_US + 3, 1);

        frame('{1400, 1400, 1400, 1400, 1400}, 5'h1F, 1500);
        check("fault_cleared", fault, 0);

        // Mixed pattern with gesture already 00: no pulse.
        frames(3, '{1400, 1400, 1500, 1500, 1500}, 1600, 0, 8'h00);
        check("mixed_gesture", gesture, 0);
        check("mixed_pending", exp_q.size(), 0);

        // Open again, then one closed frame (mid-debounce when enabled).
        frames(3, '{1500, 1500, 1500, 1500, 1500}, 1600, NF, 8'h01);
        check("reopen_gesture", gesture, 8'h01);
        frames(1, '{1400, 1400, 1400, 1400, 1400}, 1500, (NF == 1) ? 1 : 0, 8'h02);
        check("closed1_pending", exp_q.size(), 0);
        check("closed1_gesture", gesture, (NF == 1) ? 8'h02 : 8'h01);

        // Reset in the middle of a pulse.
        pwm_in = 5'h1F;
        #(700 * US + 100);
        rst_n = 1'b0;
        #1;
        check("rst_gesture", gesture, 0);
        check("rst_valid", gesture_valid, 0);
        check("rst_fault", fault, 0);
        #(3 * US);
        rst_n = 1'b1;
        wv_seen = 0;
        #(700 * US);
        pwm_in = 5'h00;
        #(100 * US);
        check("partial_width_valid", wv_seen, 0);
        check("partial_mask", dut.mask, 0);
        check("partial_gesture", gesture, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
